// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 28;
    localparam int unsigned DEF_DATA_W = 128;
    localparam int unsigned DEF_BEATS  = 4;

    // Bit positions inside the one-hot grant vector.
    localparam int unsigned GNT_IC = 0;
    localparam int unsigned GNT_DC = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_e;

    // A single-beat configuration still needs a one-bit counter register.
    function automatic int unsigned cnt_width(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a contested cycle goes to whoever was not granted last.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       ic_req_i,
    input  logic       dc_req_i,
    input  owner_e     last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        gnt_o = 2'b00;
        if (ic_req_i && dc_req_i) begin
            if (last_i == OWN_IC) begin
                gnt_o[GNT_DC] = 1'b1;
            end else begin
                gnt_o[GNT_IC] = 1'b1;
            end
        end else if (dc_req_i) begin
            gnt_o[GNT_DC] = 1'b1;
        end else if (ic_req_i) begin
            gnt_o[GNT_IC] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache reads and dcache reads/writes onto one memory port,
// steering multi-beat read responses back to the owning cache.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned BEATS  = DEF_BEATS
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                ic_req_valid,
    input  logic [ADDR_W-1:0]   ic_req_addr,
    output logic                ic_req_ready,
    output logic                ic_resp_valid,

    input  logic                dc_req_valid,
    input  logic                dc_req_rw,
    input  logic [ADDR_W-1:0]   dc_req_addr,
    input  logic [DATA_W-1:0]   dc_req_data,
    input  logic [DATA_W/8-1:0] dc_req_mask,
    output logic                dc_req_ready,
    output logic                dc_resp_valid,

    output logic [DATA_W-1:0]   resp_data,

    output logic                mem_req_valid,
    output logic                mem_req_rw,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_data,
    output logic [DATA_W/8-1:0] mem_req_mask,
    input  logic                mem_req_ready,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,

    output logic                proto_err
);

    localparam int unsigned        CNT_W     = cnt_width(BEATS);
    localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BEATS - 1);

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    owner_e           last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             err_q,   err_d;

    logic [1:0]       gnt;
    logic             owner_is_dc;
    logic             owner_valid;
    logic             owner_rw;

    rr_arb2 u_rr_arb2 (
        .ic_req_i (ic_req_valid),
        .dc_req_i (dc_req_valid),
        .last_i   (last_q),
        .gnt_o    (gnt)
    );

    assign owner_is_dc = (owner_q == OWN_DC);
    assign owner_valid = owner_is_dc ? dc_req_valid : ic_req_valid;
    assign owner_rw    = owner_is_dc & dc_req_rw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= OWN_DC;
            last_q  <= OWN_IC;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    owner_d = gnt[GNT_DC] ? OWN_DC : OWN_IC;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The owner is locked in; withdrawing its request here is a protocol violation.
                if (!owner_valid) begin
                    err_d = 1'b1;
                end
                if (mem_req_ready) begin
                    last_d = owner_q;
                    if (owner_rw) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                        cnt_d   = '0;
                    end
                end
            end
            RESP: begin
                if (mem_resp_valid) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (mem_resp_valid && (state_q != RESP)) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        mem_req_valid = (state_q == ISSUE);
        mem_req_rw    = owner_rw;
        mem_req_addr  = owner_is_dc ? dc_req_addr : ic_req_addr;
        mem_req_data  = owner_is_dc ? dc_req_data : '0;
        mem_req_mask  = owner_is_dc ? dc_req_mask : '0;

        ic_req_ready  = mem_req_valid && mem_req_ready && !owner_is_dc;
        dc_req_ready  = mem_req_valid && mem_req_ready &&  owner_is_dc;

        ic_resp_valid = (state_q == RESP) && mem_resp_valid && !owner_is_dc;
        dc_resp_valid = (state_q == RESP) && mem_resp_valid &&  owner_is_dc;
    end

    assign resp_data = mem_resp_data;
    assign proto_err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

    localparam int unsigned AW    = 28;
    localparam int unsigned DW    = 128;
    localparam int unsigned MW    = DW / 8;
    localparam int          BEATS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req_valid, ic_req_ready, ic_resp_valid;
    logic [AW-1:0] ic_req_addr;
    logic          dc_req_valid, dc_req_rw, dc_req_ready, dc_resp_valid;
    logic [AW-1:0] dc_req_addr;
    logic [DW-1:0] dc_req_data;
    logic [MW-1:0] dc_req_mask;
    logic [DW-1:0] resp_data;
    logic          mem_req_valid, mem_req_rw, mem_req_ready, mem_resp_valid;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data, mem_resp_data;
    logic [MW-1:0] mem_req_mask;
    logic          proto_err;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Transaction-level model: owner 0=icache 1=dcache, beats still owed, sticky error.
    bit m_issuing    = 1'b0;
    int m_beats_left = 0;
    bit m_owner      = 1'b1;
    bit m_last       = 1'b0;
    bit m_err        = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .ic_req_valid   (ic_req_valid),
        .ic_req_addr    (ic_req_addr),
        .ic_req_ready   (ic_req_ready),
        .ic_resp_valid  (ic_resp_valid),
        .dc_req_valid   (dc_req_valid),
        .dc_req_rw      (dc_req_rw),
        .dc_req_addr    (dc_req_addr),
        .dc_req_data    (dc_req_data),
        .dc_req_mask    (dc_req_mask),
        .dc_req_ready   (dc_req_ready),
        .dc_resp_valid  (dc_resp_valid),
        .resp_data      (resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_mask   (mem_req_mask),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .proto_err      (proto_err)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_issuing    = 1'b0;
            m_beats_left = 0;
            m_owner      = 1'b1;
            m_last       = 1'b0;
            m_err        = 1'b0;
        end else begin
            if (mem_resp_valid && m_beats_left == 0) m_err = 1'b1;
            if (m_issuing) begin
                if (!(m_owner ? dc_req_valid : ic_req_valid)) m_err = 1'b1;
                if (mem_req_ready) begin
                    m_last    = m_owner;
                    m_issuing = 1'b0;
                    if (!(m_owner && dc_req_rw)) m_beats_left = BEATS;
                end
            end else if (m_beats_left > 0) begin
                if (mem_resp_valid) m_beats_left--;
            end else if (ic_req_valid || dc_req_valid) begin
                m_owner   = (ic_req_valid && dc_req_valid) ? !m_last : dc_req_valid;
                m_issuing = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_req_valid", 128'(mem_req_valid), 128'(m_issuing));
            check("ic_req_ready", 128'(ic_req_ready), 128'(m_issuing && mem_req_ready && !m_owner));
            check("dc_req_ready", 128'(dc_req_ready), 128'(m_issuing && mem_req_ready && m_owner));
            check("ic_resp_valid", 128'(ic_resp_valid), 128'(m_beats_left > 0 && mem_resp_valid && !m_owner));
            check("dc_resp_valid", 128'(dc_resp_valid), 128'(m_beats_left > 0 && mem_resp_valid && m_owner));
            check("resp_data", resp_data, mem_resp_data);
            check("proto_err", 128'(proto_err), 128'(m_err));
            if (m_issuing) begin
                check("mem_req_addr", 128'(mem_req_addr), 128'(m_owner ? dc_req_addr : ic_req_addr));
                check("mem_req_rw", 128'(mem_req_rw), 128'(m_owner && dc_req_rw));
                check("mem_req_data", mem_req_data, m_owner ? dc_req_data : 128'(0));
                check("mem_req_mask", 128'(mem_req_mask), 128'(m_owner ? dc_req_mask : 16'(0)));
            end
        end
    end

    task automatic clear_inputs();
        ic_req_valid   = 1'b0;
        ic_req_addr    = '0;
        dc_req_valid   = 1'b0;
        dc_req_rw      = 1'b0;
        dc_req_addr    = '0;
        dc_req_data    = '0;
        dc_req_mask    = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic ic_read(input logic [AW-1:0] addr, output int n_rdy, output int n_ic, output int n_dc);
        n_rdy = 0;
        n_ic  = 0;
        n_dc  = 0;
        for (int t = 0; t < 8; t++) begin
            ic_req_valid   = (t < 2);
            ic_req_addr    = addr;
            mem_req_ready  = 1'b1;
            mem_resp_valid = (t >= 2 && t < 6);
            mem_resp_data  = rnd128();
            @(negedge clk);
            if (t == 0) check("ic_no_same_cycle_issue", 128'(mem_req_valid), 128'(0));
            if (t == 1) begin
                check("ic_issue_next_cycle", 128'(mem_req_valid), 128'(1));
                check("ic_issue_addr", 128'(mem_req_addr), 128'(addr));
            end
            if (t == 7) check("ic_back_to_idle", 128'(mem_req_valid), 128'(0));
            if (ic_req_ready)  n_rdy++;
            if (ic_resp_valid) n_ic++;
            if (dc_resp_valid) n_dc++;
            @(posedge clk);
            #1;
        end
        clear_inputs();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_rdy, n_ic, n_dc;
        int grant [4];
        int ng;
        int pulses;
        bit ic_pend, dc_pend;

        clear_inputs();
        reset = 1'b0;
        #2;
        do_reset();
        chk_en = 1'b1;

        // Reset state.
        @(negedge clk);
        check("reset_mem_req_valid", 128'(mem_req_valid), 128'(0));
        check("reset_proto_err", 128'(proto_err), 128'(0));
        @(posedge clk);
        #1;

        // Single icache read.
        do_reset();
        ic_read(28'h1000, n_rdy, n_ic, n_dc);
        check("ic_ready_pulses", 128'(n_rdy), 128'(1));
        check("ic_resp_beats", 128'(n_ic), 128'(4));
        check("ic_dc_resp_quiet", 128'(n_dc), 128'(0));

        // Contested reads: dcache first after reset, then strict alternation.
        do_reset();
        foreach (grant[i]) grant[i] = 2;
        ng = 0;
        for (int t = 0; t < 40; t++) begin
            ic_req_valid   = 1'b1;
            dc_req_valid   = 1'b1;
            dc_req_rw      = 1'b0;
            mem_req_ready  = 1'b1;
            mem_resp_valid = (m_beats_left > 0);
            @(negedge clk);
            if (ng < 4 && dc_req_ready) begin grant[ng] = 1; ng++; end
            else if (ng < 4 && ic_req_ready) begin grant[ng] = 0; ng++; end
            @(posedge clk);
            #1;
        end
        check("rr_grant0_dc", 128'(grant[0]), 128'(1));
        check("rr_grant1_ic", 128'(grant[1]), 128'(0));
        check("rr_grant2_dc", 128'(grant[2]), 128'(1));
        check("rr_grant3_ic", 128'(grant[3]), 128'(0));

        // dcache write with memory stalling three cycles.
        do_reset();
        pulses = 0;
        for (int t = 0; t < 7; t++) begin
            dc_req_valid   = (t <= 4);
            dc_req_rw      = 1'b1;
            dc_req_addr    = 28'h0ABCDE0;
            dc_req_data    = {16{8'hA5}};
            dc_req_mask    = 16'hFFFF;
            mem_req_ready  = (t == 4);
            mem_resp_valid = (t == 5);
            @(negedge clk);
            if (t >= 1 && t <= 4) begin
                check("wr_valid", 128'(mem_req_valid), 128'(1));
                check("wr_rw", 128'(mem_req_rw), 128'(1));
                check("wr_data", mem_req_data, {16{8'hA5}});
                check("wr_mask", 128'(mem_req_mask), 128'(16'hFFFF));
                check("wr_addr", 128'(mem_req_addr), 128'(28'h0ABCDE0));
            end
            if (dc_req_ready) pulses++;
            if (t == 4) check("wr_ready_cycle4", 128'(dc_req_ready), 128'(1));
            if (t == 5) check("wr_no_resp_phase", 128'(dc_resp_valid), 128'(0));
            if (t == 6) check("wr_stray_beat_in_idle", 128'(proto_err), 128'(1));
            @(posedge clk);
            #1;
        end
        check("wr_ready_pulses", 128'(pulses), 128'(1));

        // Stray response beat while idle: flagged, sticky, cleared only by reset.
        do_reset();
        for (int t = 0; t < 6; t++) begin
            mem_resp_valid = (t == 1);
            @(negedge clk);
            if (t == 1) begin
                check("idle_beat_ic_resp", 128'(ic_resp_valid), 128'(0));
                check("idle_beat_dc_resp", 128'(dc_resp_valid), 128'(0));
            end
            if (t >= 2) check("err_sticky", 128'(proto_err), 128'(1));
            @(posedge clk);
            #1;
        end
        do_reset();
        @(negedge clk);
        check("err_cleared_by_reset", 128'(proto_err), 128'(0));
        @(posedge clk);
        #1;

        // Reset in the middle of a dcache read, then a clean icache read.
        do_reset();
        for (int t = 0; t < 4; t++) begin
            dc_req_valid   = 1'b1;
            dc_req_rw      = 1'b0;
            mem_req_ready  = 1'b1;
            mem_resp_valid = (t >= 2);
            @(negedge clk);
            if (t == 3) check("mid_read_beat2", 128'(dc_resp_valid), 128'(1));
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        check("rst_mem_req_valid", 128'(mem_req_valid), 128'(0));
        check("rst_dc_resp_valid", 128'(dc_resp_valid), 128'(0));
        check("rst_dc_req_ready", 128'(dc_req_ready), 128'(0));
        check("rst_ic_req_ready", 128'(ic_req_ready), 128'(0));
        check("rst_ic_resp_valid", 128'(ic_resp_valid), 128'(0));
        @(posedge clk);
        #1;
        clear_inputs();
        reset = 1'b0;
        ic_read(28'h2340, n_rdy, n_ic, n_dc);
        check("post_rst_ic_ready", 128'(n_rdy), 128'(1));
        check("post_rst_ic_beats", 128'(n_ic), 128'(4));
        check("post_rst_err", 128'(proto_err), 128'(0));

        // Gapped response beats at RESP cycles 1, 4, 5, 9.
        do_reset();
        pulses = 0;
        for (int t = 0; t < 13; t++) begin
            ic_req_valid   = (t < 2);
            ic_req_addr    = 28'h0000040;
            mem_req_ready  = 1'b1;
            mem_resp_valid = (t == 2 || t == 5 || t == 6 || t == 10 || t == 11);
            mem_resp_data  = rnd128();
            @(negedge clk);
            if (t >= 2 && t <= 10) begin
                check("gap_beat_align", 128'(ic_resp_valid), 128'(t == 2 || t == 5 || t == 6 || t == 10));
                if (ic_resp_valid) pulses++;
            end
            if (t == 11) check("gap_idle_after_last", 128'(ic_resp_valid), 128'(0));
            @(posedge clk);
            #1;
        end
        check("gap_beat_count", 128'(pulses), 128'(4));
        check("gap_extra_beat_flagged", 128'(proto_err), 128'(1));

        // Random traffic against the model.
        do_reset();
        ic_pend = 1'b0;
        dc_pend = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!ic_pend && $urandom_range(0, 3) == 0) begin
                ic_pend     = 1'b1;
                ic_req_addr = AW'($urandom);
            end
            if (!dc_pend && $urandom_range(0, 3) == 0) begin
                dc_pend     = 1'b1;
                dc_req_rw   = 1'($urandom_range(0, 1));
                dc_req_addr = AW'($urandom);
                dc_req_data = rnd128();
                dc_req_mask = MW'($urandom);
            end
            if (ic_pend && $urandom_range(0, 399) == 0) ic_pend = 1'b0;
            if (dc_pend && $urandom_range(0, 399) == 0) dc_pend = 1'b0;
            ic_req_valid   = ic_pend;
            dc_req_valid   = dc_pend;
            mem_req_ready  = 1'($urandom_range(0, 1));
            mem_resp_valid = (m_beats_left > 0) ? ($urandom_range(0, 2) != 0)
                                                : ($urandom_range(0, 299) == 0);
            mem_resp_data  = rnd128();
            @(negedge clk);
            if (ic_req_ready) ic_pend = 1'b0;
            if (dc_req_ready) dc_pend = 1'b0;
            @(posedge clk);
            #1;
            if ($urandom_range(0, 499) == 0) begin
                ic_pend = 1'b0;
                dc_pend = 1'b0;
                do_reset();
            end
        end

        clear_inputs();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
